path_node_capture: RTL and testbench

- Bus snooper and buffer directly downstream of the t2b_riscv_cpu data-memory write port.
- Captures every NODE_POINT write (0x02000003) and the path-complete write (0x02000004 == 1).
- Queues captured nodes in a FIFO and presents them in order, over a valid/ready handshake, to the bot navigation unit.
- Replaces the bench-only node checking with synthesizable hardware.

---
 rtl/path_capture_pkg.sv | 20 ++
 rtl/path_fifo.sv | 60 ++++++
 rtl/path_node_capture.sv | 110 +++++++++++
 tb/tb_path_node_capture.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_capture_pkg.sv
// Shared constants and types for the path node capture block.
// Holds bus addresses, node width, FSM encoding and err bit indices.
package path_capture_pkg;

    localparam logic [31:0] NODE_ADDR_C = 32'h0200_0003;
    localparam logic [31:0] DONE_ADDR_C = 32'h0200_0004;
    localparam int          NODE_W_C    = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DRAIN    = 2'd2,
        COMPLETE = 2'd3
    } pathState_t;

    localparam int ERR_OVF   = 0;
    localparam int ERR_RANGE = 1;
    localparam int ERR_LATE  = 2;

endpackage

// File: rtl/path_fifo.sv
// Sync FIFO with first-word-fall-through head, count and flush.
// Ports: clk, reset (async low), flush, push/pushData, pop,
//        headData (0 when empty), empty, full, count.
module path_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             pushData,
    input  logic                     pop,
    output logic [W-1:0]             headData,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          pushOk;
    logic          popOk;

    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(DEPTH));
    assign popOk  = pop && !flush && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pushOk = push && !flush && (!full || popOk);

    // Head reads zero when empty so the output never shows stale data.
    assign headData = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (popOk)  rdPtr <= rdPtr + 1'b1;
            count <= count + {{AW{1'b0}}, pushOk}
                           - {{AW{1'b0}}, popOk};
        end
    end

endmodule

// File: rtl/path_node_capture.sv
// Snoops CPU stores for node-point and path-complete writes and
// buffers nodes for the navigation unit over valid/ready.
// Ports: clk, reset (async low), MemWrite/DataAdr/WriteData (bus),
//        clear (sync flush), node_valid/node_data/node_ready/node_last,
//        path_done, count, err = {late, range, overflow} (sticky).
module path_node_capture
    import path_capture_pkg::*;
#(
    parameter int          NODE_W    = NODE_W_C,
    parameter int          DEPTH     = 32,
    parameter logic [31:0] NODE_ADDR = NODE_ADDR_C,
    parameter logic [31:0] DONE_ADDR = DONE_ADDR_C
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemWrite,
    input  logic [31:0]                DataAdr,
    input  logic [31:0]                WriteData,
    input  logic                       clear,
    output logic                       node_valid,
    output logic [NODE_W-1:0]          node_data,
    input  logic                       node_ready,
    output logic                       node_last,
    output logic                       path_done,
    output logic [$clog2(DEPTH):0]     count,
    output logic [2:0]                 err
);

    localparam int CW = $clog2(DEPTH) + 1;

    pathState_t state;
    logic       nodeHit;
    logic       doneHit;
    logic       inRange;
    logic       openState;
    logic       lateState;
    logic       pushReq;
    logic       popReq;
    logic       fifoEmpty;
    logic       fifoFull;
    logic       ovf;
    logic       heldAfter;

    assign nodeHit   = MemWrite && (DataAdr == NODE_ADDR);
    assign doneHit   = MemWrite && (DataAdr == DONE_ADDR)
                    && (WriteData == 32'd1);
    assign inRange   = (WriteData[31:NODE_W] == '0);
    assign openState = (state == IDLE) || (state == COLLECT);
    assign lateState = (state == DRAIN) || (state == COMPLETE);

    assign pushReq = nodeHit && inRange && openState && !clear;
    assign popReq  = node_valid && node_ready && !clear;
    assign ovf     = pushReq && fifoFull && !popReq;

    // Entries left after this edge on a done write (no push can coincide).
    assign heldAfter = (count != '0)
                    && !(popReq && (count == CW'(1)));

    assign node_valid = !fifoEmpty;
    assign node_last  = node_valid && (state == DRAIN)
                     && (count == CW'(1));
    assign path_done  = (state == COMPLETE);

    path_fifo #(
        .W     (NODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (clear),
        .push     (pushReq),
        .pushData (WriteData[NODE_W-1:0]),
        .pop      (popReq),
        .headData (node_data),
        .empty    (fifoEmpty),
        .full     (fifoFull),
        .count    (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            err   <= '0;
        end else if (clear) begin
            state <= IDLE;
            err   <= '0;
        end else begin
            if (nodeHit && !inRange) err[ERR_RANGE] <= 1'b1;
            if (nodeHit && lateState) err[ERR_LATE] <= 1'b1;
            if (ovf) err[ERR_OVF] <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (doneHit)      state <= COMPLETE;
                    else if (pushReq) state <= COLLECT;
                end
                COLLECT: begin
                    if (doneHit)
                        state <= heldAfter ? DRAIN : COMPLETE;
                end
                DRAIN: begin
                    if (popReq && (count == CW'(1)))
                        state <= COMPLETE;
                end
                COMPLETE: state <= COMPLETE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_path_node_capture.sv
// Randomized self-checking bench for path_node_capture.
// Reference model: node queue, done-seen flag and sticky error bits.
module tb_path_node_capture;

    localparam logic [31:0] NODE_A = 32'h0200_0003;
    localparam logic [31:0] DONE_A = 32'h0200_0004;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        clear;
    logic        node_valid;
    logic [4:0]  node_data;
    logic        node_ready;
    logic        node_last;
    logic        path_done;
    logic [5:0]  count;
    logic [2:0]  err;

    int checks   = 0;
    int failures = 0;

    logic [4:0] mq[$];
    bit         mDone;
    logic [2:0] mErr;
    logic [4:0] vals [64];

    path_node_capture dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .clear      (clear),
        .node_valid (node_valid),
        .node_data  (node_data),
        .node_ready (node_ready),
        .node_last  (node_last),
        .path_done  (path_done),
        .count      (count),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] expVec();
        logic v;
        logic [4:0] h;
        v = (mq.size() > 0);
        h = v ? mq[0] : 5'd0;
        return {v, h, mDone && (mq.size() == 1),
                mDone && (mq.size() == 0),
                6'(mq.size()), mErr};
    endfunction

    function automatic logic [16:0] dutVec();
        return {node_valid, node_data, node_last,
                path_done, count, err};
    endfunction

    function automatic void modelReset();
        mq.delete();
        mDone = 1'b0;
        mErr  = 3'b000;
    endfunction

    // One bus cycle: hold inputs over a rising edge, advance the model.
    task automatic drive(input logic mw, input logic [31:0] adr,
                         input logic [31:0] wd, input logic rdy,
                         input logic clr);
        bit popping;
        bit pushing;
        MemWrite   = mw;
        DataAdr    = adr;
        WriteData  = wd;
        node_ready = rdy;
        clear      = clr;
        @(posedge clk);
        if (!reset || clr) begin
            modelReset();
        end else begin
            popping = (mq.size() > 0) && rdy;
            pushing = 1'b0;
            if (mw && adr == NODE_A) begin
                if (wd[31:5] != 0) mErr[1] = 1'b1;
                if (mDone) mErr[2] = 1'b1;
                if (wd[31:5] == 0 && !mDone) begin
                    if (mq.size() == 32 && !popping)
                        mErr[0] = 1'b1;
                    else
                        pushing = 1'b1;
                end
            end
            if (popping) void'(mq.pop_front());
            if (pushing) mq.push_back(wd[4:0]);
            if (mw && adr == DONE_A && wd == 32'd1) mDone = 1'b1;
        end
        #1;
    endtask

    task automatic storeNode(input logic [31:0] v, input logic rdy);
        drive(1'b1, NODE_A, v, rdy, 1'b0);
    endtask

    task automatic doneWrite(input logic [31:0] v, input logic rdy);
        drive(1'b1, DONE_A, v, rdy, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    task automatic doClear();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        clear = 1'b0; node_ready = 1'b0;
        modelReset();
        #1;
        checks++;
        if (dutVec() !== 17'd0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", dutVec());
        end
        storeNode(32'd5, 1'b0);
        checks++;
        if (node_valid !== 1'b0 || count !== 6'd0) begin
            failures++;
            $display("FAIL reset_hold v=%b c=%0d exp 0/0",
                     node_valid, count);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_path();
        logic [16:0] e;
        logic [31:0] seq [3];
        seq[0] = 32'd0; seq[1] = 32'd4; seq[2] = 32'd7;
        doClear();
        for (int i = 0; i < 3; i++) begin
            storeNode(seq[i], 1'b1);
            e = expVec();
            checks++;
            if (dutVec() !== e || node_data !== seq[i][4:0]) begin
                failures++;
                $display("FAIL path_store%0d got=%h exp=%h",
                         i, dutVec(), e);
            end
        end
        doneWrite(32'd1, 1'b0);
        checks++;
        if (node_last !== 1'b1 || node_data !== 5'd7
            || path_done !== 1'b0) begin
            failures++;
            $display("FAIL path_last last=%b data=%0d done=%b",
                     node_last, node_data, path_done);
        end
        idle(1'b1);
        e = expVec();
        checks++;
        if (dutVec() !== e || path_done !== 1'b1 || err !== 3'b000) begin
            failures++;
            $display("FAIL path_done got=%h exp=%h", dutVec(), e);
        end
    endtask

    task automatic test_backpressure();
        doClear();
        for (int i = 0; i < 33; i++) begin
            vals[i] = 5'($urandom_range(0, 31));
            storeNode({27'd0, vals[i]}, 1'b0);
        end
        checks++;
        if (count !== 6'd32 || err !== 3'b001) begin
            failures++;
            $display("FAIL bp_full count=%0d err=%b exp 32/001",
                     count, err);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (node_valid !== 1'b1 || node_data !== vals[i]) begin
                failures++;
                $display("FAIL bp_drain%0d got=%0d exp=%0d",
                         i, node_data, vals[i]);
            end
            idle(1'b1);
        end
        checks++;
        if (node_valid !== 1'b0 || count !== 6'd0) begin
            failures++;
            $display("FAIL bp_empty v=%b c=%0d", node_valid, count);
        end
    endtask

    task automatic test_range_late();
        doClear();
        storeNode(32'h25, 1'b0);
        checks++;
        if (count !== 6'd0 || err !== 3'b010) begin
            failures++;
            $display("FAIL range count=%0d err=%b exp 0/010",
                     count, err);
        end
        doneWrite(32'd1, 1'b0);
        storeNode(32'd3, 1'b0);
        checks++;
        if (count !== 6'd0 || err !== 3'b110 || path_done !== 1'b1) begin
            failures++;
            $display("FAIL late count=%0d err=%b done=%b",
                     count, err, path_done);
        end
    endtask

    task automatic test_done_data();
        doClear();
        storeNode(32'd9, 1'b0);
        doneWrite(32'd0, 1'b0);
        checks++;
        if (path_done !== 1'b0 || node_last !== 1'b0 || count !== 6'd1) begin
            failures++;
            $display("FAIL done0 done=%b last=%b count=%0d",
                     path_done, node_last, count);
        end
        storeNode(32'd11, 1'b1);
        checks++;
        if (node_data !== 5'd11 || count !== 6'd1 || err !== 3'b000) begin
            failures++;
            $display("FAIL done0_open data=%0d count=%0d err=%b",
                     node_data, count, err);
        end
        idle(1'b1);
        doneWrite(32'd1, 1'b0);
        checks++;
        if (path_done !== 1'b1 || node_valid !== 1'b0) begin
            failures++;
            $display("FAIL done1_empty done=%b v=%b",
                     path_done, node_valid);
        end
    endtask

    task automatic test_full_pushpop();
        doClear();
        for (int i = 0; i < 32; i++) begin
            vals[i] = 5'($urandom_range(0, 31));
            storeNode({27'd0, vals[i]}, 1'b0);
        end
        storeNode(32'd17, 1'b1);
        checks++;
        if (count !== 6'd32 || err !== 3'b000 || node_data !== vals[1]) begin
            failures++;
            $display("FAIL full_pp count=%0d err=%b data=%0d exp=%0d",
                     count, err, node_data, vals[1]);
        end
    endtask

    task automatic test_clear();
        doClear();
        storeNode(32'h40, 1'b0);
        for (int i = 0; i < 5; i++) storeNode(32'(i + 1), 1'b0);
        doneWrite(32'd1, 1'b0);
        checks++;
        if (count !== 6'd5 || path_done !== 1'b0 || err !== 3'b010) begin
            failures++;
            $display("FAIL clr_pre count=%0d done=%b err=%b",
                     count, path_done, err);
        end
        drive(1'b1, NODE_A, 32'd2, 1'b1, 1'b1);
        checks++;
        if (dutVec() !== 17'd0) begin
            failures++;
            $display("FAIL clr_flush got=%h exp=0", dutVec());
        end
        storeNode(32'd6, 1'b0);
        checks++;
        if (node_valid !== 1'b1 || node_data !== 5'd6 || count !== 6'd1) begin
            failures++;
            $display("FAIL clr_idle v=%b data=%0d count=%0d",
                     node_valid, node_data, count);
        end
    endtask

    task automatic test_async_reset();
        doClear();
        for (int i = 0; i < 3; i++) storeNode(32'(i + 20), 1'b0);
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checks++;
        if (dutVec() !== 17'd0) begin
            failures++;
            $display("FAIL async_rst got=%h exp=0", dutVec());
        end
        storeNode(32'd8, 1'b1);
        checks++;
        if (node_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_glitch v=%b exp=0", node_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        storeNode(32'd8, 1'b0);
        checks++;
        if (dutVec() !== expVec()) begin
            failures++;
            $display("FAIL rst_resume got=%h exp=%h", dutVec(), expVec());
        end
    endtask

    task automatic test_random();
        logic [31:0] adr;
        logic [31:0] wd;
        logic        mw;
        logic [16:0] e;
        int          rdyBias;
        doClear();
        for (int n = 0; n < 600; n++) begin
            rdyBias = (n / 100) % 2 == 0 ? 30 : 80;
            mw = ($urandom_range(0, 99) < 70);
            case ($urandom_range(0, 9))
                0: adr = DONE_A;
                1: adr = 32'h0200_0005;
                2: adr = 32'h1200_0003;
                default: adr = NODE_A;
            endcase
            if (adr == DONE_A)
                wd = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'd1;
            else if ($urandom_range(0, 15) == 0)
                wd = $urandom;
            else
                wd = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 59) == 0) begin
                drive(mw, adr, wd, 1'b1, 1'b1);
            end else begin
                drive(mw, adr, wd,
                      ($urandom_range(0, 99) < rdyBias), 1'b0);
            end
            e = expVec();
            checks++;
            if (dutVec() !== e) begin
                failures++;
                $display("FAIL rand%0d got=%h exp=%h", n, dutVec(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_path();
        test_backpressure();
        test_range_late();
        test_done_data();
        test_full_pushpop();
        test_clear();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
